prog_sequencer: RTL

- Parametrised successor to the fixed-width PC plus hard-coded done compare.
- Owns program-counter update, the req/done start handshake, stall handling, halt/finish detection and a cycle watchdog for the single-issue core.
- Sits between the Control decoder/ALU flags and instr_ROM; it drives prog_ctr and receives branch/jump/stall/halt from the datapath.

---
 rtl/seq_pkg.sv | 20 ++
 rtl/seq_next_pc.sv | 48 ++++
 rtl/prog_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types for the program sequencer: the run FSM state and the next-PC
// select code produced by the next-PC decoder.
//   seq_state_t : IDLE / RUN / DONE
//   pc_sel_t    : HOLD / INC / ABS / REL
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    INC  = 2'd1,
    ABS  = 2'd2,
    REL  = 2'd3
  } pc_sel_t;

endpackage : seq_pkg

// File: rtl/seq_next_pc.sv
// Combinational next-PC decoder for the single-issue core.
// Ports: pc_i/target_i (D bits) and branch/jump/stall controls in;
//        next_pc_o (D bits) and the chosen select code sel_o out.
module seq_next_pc
  import seq_pkg::*;
#(
  parameter int unsigned D = 12
) (
  input  logic [D-1:0] pc_i,
  input  logic [D-1:0] target_i,
  input  logic         branch_en_i,
  input  logic         cond_i,
  input  logic         reljump_en_i,
  input  logic         absjump_en_i,
  input  logic         stall_i,
  output logic [D-1:0] next_pc_o,
  output pc_sel_t      sel_o
);

  logic taken;
  assign taken = branch_en_i & cond_i;

  always_comb begin
    sel_o = INC;
    // A stall masks the branch entirely; Control re-presents it afterwards.
    if (stall_i) begin
      sel_o = HOLD;
    end else if (taken && absjump_en_i) begin
      // Absolute wins when both jump enables are set.
      sel_o = ABS;
    end else if (taken && reljump_en_i) begin
      sel_o = REL;
    end
  end

  always_comb begin
    next_pc_o = pc_i;
    case (sel_o)
      HOLD:    next_pc_o = pc_i;
      INC:     next_pc_o = pc_i + D'(1);
      ABS:     next_pc_o = target_i;
      // Two's-complement offset; the add simply wraps at D bits.
      REL:     next_pc_o = pc_i + target_i;
      default: next_pc_o = pc_i;
    endcase
  end

endmodule : seq_next_pc

// File: rtl/prog_sequencer.sv
// Program sequencer: PC update, req/done four-phase start handshake, stall
// handling, halt / done-address finish detection and a cycle watchdog.
// Ports: clk, reset (async active-low), req, branch/jump/stall/halt controls
//        and target in; prog_ctr, fetch_en, busy, done, timeout, cycle_cnt out.
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned D          = 12,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned DONE_ADDR  = 105,
  parameter bit          DONE_EN    = 1'b1,
  parameter int unsigned CW         = 16,
  parameter int unsigned MAX_CYCLES = 65535
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          branch_en,
  input  logic          cond,
  input  logic          reljump_en,
  input  logic          absjump_en,
  input  logic [D-1:0]  target,
  input  logic          stall,
  input  logic          halt,
  output logic [D-1:0]  prog_ctr,
  output logic          fetch_en,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_cnt
);

  localparam logic [D-1:0]  START_PC = D'(START_ADDR);
  localparam logic [D-1:0]  DONE_PC  = D'(DONE_ADDR);
  // Last count value still allowed in RUN; reaching it ends the run.
  localparam logic [CW-1:0] WD_LAST  = CW'(MAX_CYCLES - 1);

  seq_state_t    state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  logic [D-1:0]  npc;
  pc_sel_t       npc_sel;
  logic          in_run;
  logic          at_done_addr;
  logic          wd_hit;

  seq_next_pc #(
    .D (D)
  ) u_next_pc (
    .pc_i         (pc_q),
    .target_i     (target),
    .branch_en_i  (branch_en),
    .cond_i       (cond),
    .reljump_en_i (reljump_en),
    .absjump_en_i (absjump_en),
    .stall_i      (stall),
    .next_pc_o    (npc),
    .sel_o        (npc_sel)
  );

  assign in_run       = (state_q == RUN);
  assign at_done_addr = DONE_EN && (pc_q == DONE_PC);
  assign wd_hit       = (cnt_q == WD_LAST);

  // Both suppressing conditions come from registered state, so fetch_en never
  // depends on a datapath input. A halt instruction is itself fetched and
  // executed; the run ends on the edge that follows it.
  assign fetch_en  = in_run && !at_done_addr && !wd_hit;
  assign busy      = in_run;
  assign done      = (state_q == DONE);
  assign prog_ctr  = pc_q;
  assign timeout   = timeout_q;
  assign cycle_cnt = cnt_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        // Previous run's cycle_cnt/timeout stay visible until a new req.
        if (req) begin
          state_d   = RUN;
          pc_d      = START_PC;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      RUN: begin
        // Finishing cycles hold PC and count; cycle_cnt therefore reports
        // the number of RUN cycles that advanced or stalled the program.
        if (at_done_addr) begin
          state_d = DONE;
        end else if (wd_hit) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else if (!stall && halt) begin
          state_d = DONE;
        end else begin
          if (npc_sel != HOLD) begin
            pc_d = npc;
          end
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
        end
      end
      DONE: begin
        // done is held until the requester drops req.
        if (!req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= START_PC;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule : prog_sequencer
